mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle CPU control unit (12-state Moore FSM) driving the memory, register-file and ALU/PC-select controls.
// Latency: controls are registered alongside the state; R 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2 cycles, plus 1 per memory wait cycle.
// Backpressure: mem_ready=0 holds IF, MRD and MWR; it is ignored in every other state.
// Ports: clk, rst_n (synchronous, active-low); opcode (IR[31:26]); mem_ready;
//        memory/datapath strobes; alu_src_b, alu_op, pc_source selects; illegal, state, instr_count status.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_EXR   = 4'd6,
        S_WBR   = 4'd7,
        S_BEQ   = 4'd8,
        S_JMP   = 4'd9,
        S_EXI   = 4'd10,
        S_WBI   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t state_q;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl;
    logic   retire;

    function automatic logic legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Moore decode; undecoded states fall through to all-zero controls.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_IF: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;   // qualified by mem_ready at the output
                c.pc_write  = 1'b1;   // qualified by mem_ready at the output
                c.alu_src_b = 2'b01;
            end
            S_ID:    c.alu_src_b = 2'b11;
            S_MADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXR: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_WBR: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_EXI: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_WBI:   c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic rdy);
        state_t n;
        n = S_IF;
        case (s)
            S_IF:  n = rdy ? S_ID : S_IF;
            S_ID: begin
                case (op)
                    OP_RTYPE:     n = S_EXR;
                    OP_LW, OP_SW: n = S_MADDR;
                    OP_BEQ:       n = S_BEQ;
                    OP_J:         n = S_JMP;
                    OP_ADDI:      n = S_EXI;
                    default:      n = S_IF;
                endcase
            end
            S_MADDR: n = (op == OP_LW) ? S_MRD : S_MWR;
            S_MRD:   n = rdy ? S_MWB : S_MRD;
            S_MWR:   n = rdy ? S_IF : S_MWR;
            S_EXR:   n = S_WBR;
            S_EXI:   n = S_WBI;
            default: n = S_IF;   // MWB, WBR, BEQ, JMP, WBI and unused codes
        endcase
        return n;
    endfunction

    // Edges that complete an instruction; an MWR edge only counts once the write lands.
    assign retire = (state_q == S_MWB) || (state_q == S_WBR) || (state_q == S_BEQ) ||
                    (state_q == S_JMP) || (state_q == S_WBI) ||
                    ((state_q == S_MWR) && mem_ready);

    // Controls are registered from the next state so they are glitch-free in the new state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IF;
            ctrl_q      <= decode(S_IF);
            instr_count <= 16'd0;
        end else begin
            state_q <= next_state(state_q, opcode, mem_ready);
            ctrl_q  <= decode(next_state(state_q, opcode, mem_ready));
            if (retire) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

    // Reset blanks every control immediately; the IF fetch strobes only fire on the completing cycle.
    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            ctrl = ctrl_q;
            if (state_q == S_IF) begin
                ctrl.ir_write = ctrl_q.ir_write & mem_ready;
                ctrl.pc_write = ctrl_q.pc_write & mem_ready;
            end
        end
    end

    assign illegal       = rst_n && (state_q == S_ID) && !legal_op(opcode);
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = state_q;

endmodule
